pushbutton_conditioner: RTL and testbench
=========================================

Name: pushbutton_conditioner

Overview:
Input stage directly upstream of the 4-bit uP's PUSHBUTTONS port. It synchronises raw, asynchronous, bouncing pushbutton levels into the clk domain and debounces each bit. It presents a nibble to the uP that changes only during the fetch phase, so an IN instruction never sees a value change mid-instruction. It also emits one-cycle press pulses for future interrupt or edge-detect use.

Parameters:
NBTN, 4, number of buttons; fixed at 4 for the uP nibble.
DEBOUNCE_CYCLES, 4, consecutive differing synchronised samples needed before a change is accepted; legal range 1..255.

Ports:
clk  in  1  system clock, same clock as the uP.
reset  in  1  asynchronous, active-low reset: reset=0 clears all state immediately.
btn_raw  in  NBTN  raw button levels, asynchronous to clk, may bounce.
phase  in  1  uP PHASE; 0 = fetch, 1 = execute.
btn_out  out  NBTN  conditioned nibble; drives uP PUSHBUTTONS.
btn_db  out  NBTN  debounced level, before the phase hold.
btn_rise  out  NBTN  one-cycle pulse per bit on each debounced 0->1 transition.

Behaviour:
- Reset (reset=0, async): sync flops, counters, btn_db, btn_out and btn_rise all go to 0. Per-bit FSM goes to STABLE. No pulse is generated on reset entry.
- Synchroniser: 2 flops per bit, reset 0. sync = btn_raw delayed 2 clk edges.
- Debounce, per bit, independent of other bits. Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - STABLE:
    - sync == btn_db: stay in STABLE, cnt = 0.
    - sync != btn_db: if DEBOUNCE_CYCLES == 1, toggle btn_db this edge and stay in STABLE; otherwise cnt = 1 and go to COUNTING.
  - COUNTING:
    - sync == btn_db (bounce): cnt = 0, go to STABLE, btn_db unchanged.
    - sync != btn_db and cnt == DEBOUNCE_CYCLES-1: toggle btn_db, cnt = 0, go to STABLE.
    - sync != btn_db otherwise: cnt++.
  - Net effect: a change is accepted after exactly DEBOUNCE_CYCLES consecutive differing samples.
  - Latency from a clean btn_raw edge to btn_db changing is 2 + DEBOUNCE_CYCLES clk edges.
  - The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- btn_rise[i]:
  - Registered; equals 1 for exactly the one cycle following the edge where btn_db[i] went 0->1.
  - No pulse on 1->0.
  - Not gated by phase.
- btn_out: at each clk edge where phase == 0, btn_out <= btn_db; while phase == 1, btn_out holds. This adds 1 cycle of latency when phase == 0.
- Simultaneous events:
  - A btn_db toggle on the same edge as a phase 1->0 transition: btn_out takes the new value on the next edge.
  - Multiple bits may toggle and pulse in the same cycle.
- Reset release with btn_raw held high: treated as a press. btn_db rises after 2 + DEBOUNCE_CYCLES edges and btn_rise pulses once.
- Reset asserted mid-count: the count is lost; debouncing restarts from STABLE with btn_db = 0.
- DEBOUNCE_CYCLES == 0 is illegal; an elaboration-time assertion is required.

Decomposition:
- Shared package pbc_pkg holds:
  - localparam NBTN = 4;
  - typedef enum logic {STABLE, COUNTING} db_state_t;
- Sub-module debounce_bit (params DEBOUNCE_CYCLES; ports clk, reset, sync_in, db_out, rise) contains the FSM, counter and rise pulse for one bit.
- The top contains the synchroniser, a generate loop of NBTN debounce_bit instances, and the phase-hold register.

Test Plan:
(Clock period 10, DEBOUNCE_CYCLES=4.)
1. Reset: pulse reset low at t=1, btn_raw=0000 -> all outputs 0000 during and after reset.
2. Clean press: btn_raw 0000->0110 at edge k, phase held 0 -> btn_db=0110 at edge k+6; btn_rise=0110 for one cycle; btn_out=0110 at edge k+7.
3. Bounce rejection: btn_raw[0] goes 0->1 for 3 cycles, back to 0 for 1 cycle, then 1 steady -> no change during the bounce; btn_db[0]=1 exactly 6 edges after the final rise; single btn_rise[0] pulse.
4. Phase hold: btn_db changes 0000->1001 while phase=1 -> btn_out stays 0000 until the first edge with phase=0, then becomes 1001.
5. Release: btn_raw 0110->0000 -> btn_db clears after 6 edges; btn_rise stays 0000.
6. Reset mid-count: reset=0 asynchronously 2 cycles into COUNTING with btn_raw=1111, then released -> immediate zeros; btn_db=1111 6 edges after release; one btn_rise=1111 pulse.

Source files
------------

// File: rtl/pbc_pkg.sv
// Shared definitions for the pushbutton conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pbc_pkg;

    localparam int NBTN = 4;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: accepts a level change after DEBOUNCE_CYCLES consecutive differing samples.
// Latency: DEBOUNCE_CYCLES clk edges from sync_in change to db_out; rise registered alongside db_out.
// Backpressure: none; free-running every clk.
module debounce_bit
    import pbc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic db_out,
    output logic rise
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    db_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic            db_q;
    logic            rise_q;

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cycles
            $error("debounce_bit: DEBOUNCE_CYCLES must be in 1..255");
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (sync_in != db_q) begin
                        // A one-sample filter accepts the change immediately.
                        if (DEBOUNCE_CYCLES == 1) begin
                            db_q   <= sync_in;
                            rise_q <= sync_in;
                        end else begin
                            cnt_q   <= CNT_ONE;
                            state_q <= COUNTING;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                COUNTING: begin
                    if (sync_in == db_q) begin
                        cnt_q   <= '0;
                        state_q <= STABLE;
                    end else if (cnt_q == CNT_LAST) begin
                        db_q    <= sync_in;
                        rise_q  <= sync_in;
                        cnt_q   <= '0;
                        state_q <= STABLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= STABLE;
                end
            endcase
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Synchronises, debounces and phase-holds the raw pushbutton nibble feeding the uP.
// Latency: 2 + DEBOUNCE_CYCLES edges to btn_db/btn_rise, one more edge (phase==0) to btn_out.
// Backpressure: none; btn_out simply holds while phase==1.
module pushbutton_conditioner
    import pbc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            phase,
    output logic [NBTN-1:0] btn_out,
    output logic [NBTN-1:0] btn_db,
    output logic [NBTN-1:0] btn_rise
);

    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] btn_out_q;
    logic [NBTN-1:0] db_w;
    logic [NBTN-1:0] rise_w;

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cycles
            $error("pushbutton_conditioner: DEBOUNCE_CYCLES must be in 1..255");
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar i = 0; i < NBTN; i++) begin : g_db
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce_bit (
                .clk     (clk),
                .reset   (reset),
                .sync_in (sync2_q[i]),
                .db_out  (db_w[i]),
                .rise    (rise_w[i])
            );
        end
    endgenerate

    // Only update during fetch so an IN instruction sees a constant nibble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_out_q <= '0;
        end else if (!phase) begin
            btn_out_q <= db_w;
        end
    end

    assign btn_out  = btn_out_q;
    assign btn_db   = db_w;
    assign btn_rise = rise_w;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Self-checking bench: directed scenarios plus randomized buttons/phase/reset against a window-based model.
module tb_pushbutton_conditioner;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       phase = 1'b0;
    logic [3:0] btn_out;
    logic [3:0] btn_db;
    logic [3:0] btn_rise;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: raw samples in flight, last DC debouncer inputs, expected outputs.
    logic [3:0] samp_q[$];
    logic [3:0] win_q[$];
    logic [3:0] m_db;
    logic [3:0] m_rise;
    logic [3:0] m_out;

    always #5 clk = ~clk;

    pushbutton_conditioner #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .phase    (phase),
        .btn_out  (btn_out),
        .btn_db   (btn_db),
        .btn_rise (btn_rise)
    );

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        samp_q.delete();
        samp_q.push_back(4'b0000);
        samp_q.push_back(4'b0000);
        win_q.delete();
        m_db   = 4'b0000;
        m_rise = 4'b0000;
        m_out  = 4'b0000;
    endfunction

    // A bit flips when each of the last DC samples it saw differed from its accepted level.
    function automatic void model_edge();
        logic [3:0] din;
        logic [3:0] nxt;
        logic [3:0] w;
        bit         all_diff;
        if (!reset) begin
            model_clear();
            return;
        end
        samp_q.push_back(btn_raw);
        din = samp_q.pop_front();
        win_q.push_back(din);
        if (win_q.size() > DC) void'(win_q.pop_front());
        nxt = m_db;
        if (win_q.size() == DC) begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    w = win_q[j];
                    if (w[i] == m_db[i]) all_diff = 1'b0;
                end
                if (all_diff) nxt[i] = ~m_db[i];
            end
        end
        if (!phase) m_out = m_db;
        m_rise = nxt & ~m_db;
        m_db   = nxt;
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_eq({tag, "_db"},   btn_db,   m_db);
        check_eq({tag, "_rise"}, btn_rise, m_rise);
        check_eq({tag, "_out"},  btn_out,  m_out);
    endtask

    task automatic async_reset(input int dly);
        #dly;
        reset = 1'b0;
        #1;
        check_eq("rst_db",   btn_db,   4'b0000);
        check_eq("rst_rise", btn_rise, 4'b0000);
        check_eq("rst_out",  btn_out,  4'b0000);
        model_clear();
        tick("rst_hold");
        tick("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        model_clear();

        async_reset(1);

        // Clean press of buttons 1 and 2.
        phase   = 1'b0;
        btn_raw = 4'b0110;
        repeat (5) tick("press");
        check_eq("press_early_db", btn_db, 4'b0000);
        tick("press");
        check_eq("press_db", btn_db, 4'b0110);
        check_eq("press_rise", btn_rise, 4'b0110);
        tick("press");
        check_eq("press_out", btn_out, 4'b0110);
        check_eq("press_rise_end", btn_rise, 4'b0000);

        // Bounce on bit 0: three high samples then one low must be rejected.
        repeat (4) tick("settle");
        btn_raw = 4'b0111;
        repeat (3) tick("bounce");
        btn_raw = 4'b0110;
        tick("bounce");
        btn_raw = 4'b0111;
        repeat (5) tick("bounce");
        check_eq("bounce_hold_db", btn_db, 4'b0110);
        tick("bounce");
        check_eq("bounce_db", btn_db, 4'b0111);
        check_eq("bounce_rise", btn_rise, 4'b0001);

        // Release of all buttons: no rise pulse.
        repeat (3) tick("settle");
        btn_raw = 4'b0000;
        repeat (5) tick("release");
        check_eq("release_hold_db", btn_db, 4'b0111);
        tick("release");
        check_eq("release_db", btn_db, 4'b0000);
        check_eq("release_rise", btn_rise, 4'b0000);

        // Phase hold: btn_out frozen while executing.
        repeat (3) tick("settle");
        phase   = 1'b1;
        btn_raw = 4'b1001;
        repeat (8) tick("hold");
        check_eq("hold_out", btn_out, 4'b0000);
        check_eq("hold_db", btn_db, 4'b1001);
        phase = 1'b0;
        tick("hold");
        check_eq("hold_release_out", btn_out, 4'b1001);

        // Reset landing two samples into a count.
        async_reset(4);
        btn_raw = 4'b1111;
        repeat (4) tick("midcnt");
        async_reset(3);
        repeat (5) tick("midcnt");
        check_eq("midcnt_early_db", btn_db, 4'b0000);
        tick("midcnt");
        check_eq("midcnt_db", btn_db, 4'b1111);
        check_eq("midcnt_rise", btn_rise, 4'b1111);
        tick("midcnt");
        check_eq("midcnt_out", btn_out, 4'b1111);
        check_eq("midcnt_rise_end", btn_rise, 4'b0000);

        // Randomized buttons, phase and occasional asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, 3));
                btn_raw[idx] = ~btn_raw[idx];
            end
            if ($urandom_range(0, 4) == 0) phase = ~phase;
            if ($urandom_range(0, 399) == 0) async_reset(int'($urandom_range(1, 7)));
            else tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
